// File: rtl/counter_pkg.sv
// Shared types for the mod_counter family: count mode encoding and direction constants.
package counter_pkg;

    typedef enum logic [1:0] {
        MODE_UP     = 2'd0,
        MODE_DOWN   = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_HOLD   = 2'd3
    } count_mode_t;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/bin2gray.sv
// Combinational binary-to-Gray converter, used by mod_counter when COUNTER_GRAY_OUT_EN is defined.
module bin2gray #(
    parameter int WIDTH = 2
) (
    input  logic [WIDTH-1:0] bin_i,
    output logic [WIDTH-1:0] gray_o
);

    assign gray_o = bin_i ^ (bin_i >> 1);

endmodule

// File: rtl/mod_counter.sv
// Parametrised up/down/bounce/hold counter with load, enable and terminal-count pulse.
// Optional registered Gray output is enabled by defining COUNTER_GRAY_OUT_EN.
module mod_counter
    import counter_pkg::*;
#(
    parameter int               WIDTH = 2,
    parameter logic [WIDTH-1:0] MAX   = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] Q,
    output logic             dir,
    output logic             tc
`ifdef COUNTER_GRAY_OUT_EN
    ,
    output logic [WIDTH-1:0] gray
`endif
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    count_mode_t      mode_e;
    logic [WIDTH-1:0] q_q, q_d;
    logic             dir_q, dir_d;
    logic             tc_q, tc_d;

    assign mode_e = count_mode_t'(mode);

    // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        q_d   = q_q;
        dir_d = dir_q;
        tc_d  = 1'b0;
        if (load) begin
            // Clamp rather than truncate so the count never leaves 0..MAX.
            q_d = (load_val > MAX) ? MAX : load_val;
        end else if (en) begin
            case (mode_e)
                MODE_UP: begin
                    dir_d = DIR_UP;
                    if (q_q == MAX) begin
                        q_d  = '0;
                        tc_d = 1'b1;
                    end else begin
                        q_d = q_q + ONE;
                    end
                end
                MODE_DOWN: begin
                    dir_d = DIR_DOWN;
                    if (q_q == '0) begin
                        q_d  = MAX;
                        tc_d = 1'b1;
                    end else begin
                        q_d = q_q - ONE;
                    end
                end
                MODE_BOUNCE: begin
                    if (dir_q == DIR_UP) begin
                        if (q_q == MAX) begin
                            dir_d = DIR_DOWN;
                            q_d   = MAX - ONE;
                            tc_d  = 1'b1;
                        end else begin
                            q_d = q_q + ONE;
                        end
                    end else begin
                        if (q_q == '0) begin
                            dir_d = DIR_UP;
                            q_d   = ONE;
                            tc_d  = 1'b1;
                        end else begin
                            q_d = q_q - ONE;
                        end
                    end
                end
                default: begin
                    q_d   = q_q;
                    dir_d = dir_q;
                end
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            q_q   <= '0;
            dir_q <= DIR_UP;
            tc_q  <= 1'b0;
        end else begin
            q_q   <= q_d;
            dir_q <= dir_d;
            tc_q  <= tc_d;
        end
    end

    assign Q   = q_q;
    assign dir = dir_q;
    assign tc  = tc_q;

`ifdef COUNTER_GRAY_OUT_EN
    logic [WIDTH-1:0] gray_d, gray_q;

    // Converting the next count keeps gray aligned with Q in the same cycle.
    bin2gray #(.WIDTH(WIDTH)) u_bin2gray (
        .bin_i  (q_d),
        .gray_o (gray_d)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            gray_q <= '0;
        end else begin
            gray_q <= gray_d;
        end
    end

    assign gray = gray_q;
`endif

endmodule

// File: tb/tb_mod_counter.sv
// Directed bench for mod_counter: a WIDTH=2/MAX=3 and a WIDTH=3/MAX=5 instance,
// plus a WIDTH=3/MAX=7 Gray instance when COUNTER_GRAY_OUT_EN is defined.
module tb_mod_counter;
    import counter_pkg::*;

    localparam int UP_Q   [5]  = '{1, 2, 3, 0, 1};
    localparam int UP_TC  [5]  = '{0, 0, 0, 1, 0};
    localparam int DN_Q   [5]  = '{3, 2, 1, 0, 3};
    localparam int DN_TC  [5]  = '{1, 0, 0, 0, 1};
    localparam int BN_Q   [11] = '{1, 2, 3, 4, 5, 4, 3, 2, 1, 0, 1};
    localparam int BN_TC  [11] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    localparam int BN_DIR [11] = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 0};

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    // Instance A: WIDTH=2, MAX=3
    logic       a_en, a_load, a_dir, a_tc;
    logic [1:0] a_load_val, a_mode, a_q;

    // Instance B: WIDTH=3, MAX=5
    logic       b_en, b_load, b_dir, b_tc;
    logic [2:0] b_load_val, b_q;
    logic [1:0] b_mode;

    mod_counter #(.WIDTH(2), .MAX(2'd3)) u_dut_a (
        .clk      (clk),
        .reset    (reset),
        .en       (a_en),
        .load     (a_load),
        .load_val (a_load_val),
        .mode     (a_mode),
        .Q        (a_q),
        .dir      (a_dir),
        .tc       (a_tc)
`ifdef COUNTER_GRAY_OUT_EN
        ,
        .gray     ()
`endif
    );

    mod_counter #(.WIDTH(3), .MAX(3'd5)) u_dut_b (
        .clk      (clk),
        .reset    (reset),
        .en       (b_en),
        .load     (b_load),
        .load_val (b_load_val),
        .mode     (b_mode),
        .Q        (b_q),
        .dir      (b_dir),
        .tc       (b_tc)
`ifdef COUNTER_GRAY_OUT_EN
        ,
        .gray     ()
`endif
    );

`ifdef COUNTER_GRAY_OUT_EN
    localparam int GRAY_SEQ [8] = '{1, 3, 2, 6, 7, 5, 4, 0};
    logic       c_en, c_dir, c_tc;
    logic [2:0] c_q, c_gray, c_prev;

    mod_counter #(.WIDTH(3), .MAX(3'd7)) u_dut_c (
        .clk      (clk),
        .reset    (reset),
        .en       (c_en),
        .load     (1'b0),
        .load_val (3'd0),
        .mode     (MODE_UP),
        .Q        (c_q),
        .dir      (c_dir),
        .tc       (c_tc),
        .gray     (c_gray)
    );
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Advance one edge, then settle away from it before sampling or driving.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        a_en = 1'b0; a_load = 1'b0; a_load_val = '0; a_mode = MODE_UP;
        b_en = 1'b0; b_load = 1'b0; b_load_val = '0; b_mode = MODE_UP;
`ifdef COUNTER_GRAY_OUT_EN
        c_en = 1'b0;
`endif
        step();
        step();
        check("reset_a_q", 32'(a_q), 0);
        check("reset_a_dir", 32'(a_dir), 0);
        check("reset_a_tc", 32'(a_tc), 0);
        check("reset_b_q", 32'(b_q), 0);
`ifdef COUNTER_GRAY_OUT_EN
        check("reset_c_gray", 32'(c_gray), 0);
`endif

        // Up count from reset release: first enabled edge gives 1.
        reset = 1'b1;
        a_en  = 1'b1;
        a_mode = MODE_UP;
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("up_q[%0d]", i), 32'(a_q), UP_Q[i]);
            check($sformatf("up_tc[%0d]", i), 32'(a_tc), UP_TC[i]);
            check($sformatf("up_dir[%0d]", i), 32'(a_dir), 0);
        end

        // Down from 0.
        a_load = 1'b1; a_load_val = 2'd0;
        step();
        check("load0_q", 32'(a_q), 0);
        check("load0_tc", 32'(a_tc), 0);
        a_load = 1'b0;
        a_mode = MODE_DOWN;
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("dn_q[%0d]", i), 32'(a_q), DN_Q[i]);
            check($sformatf("dn_tc[%0d]", i), 32'(a_tc), DN_TC[i]);
            check($sformatf("dn_dir[%0d]", i), 32'(a_dir), 1);
        end

        // Reset mid-count at Q=2 with en held high.
        a_load = 1'b1; a_load_val = 2'd1;
        step();
        check("load1_q", 32'(a_q), 1);
        a_load = 1'b0;
        a_mode = MODE_UP;
        step();
        check("pre_rst_q", 32'(a_q), 2);
        reset = 1'b0;
        step();
        check("mid_rst_q", 32'(a_q), 0);
        check("mid_rst_dir", 32'(a_dir), 0);
        check("mid_rst_tc", 32'(a_tc), 0);
        reset = 1'b1;
        step();
        check("post_rst_q", 32'(a_q), 1);

        // Hold via mode 3, then via en=0.
        a_mode = MODE_HOLD;
        step();
        check("hold_mode_q", 32'(a_q), 1);
        check("hold_mode_tc", 32'(a_tc), 0);
        a_mode = MODE_UP;
        a_en = 1'b0;
        step();
        check("hold_en_q", 32'(a_q), 1);

        // Bounce on WIDTH=3, MAX=5 from 0.
        b_en = 1'b1;
        b_mode = MODE_BOUNCE;
        for (int i = 0; i < 11; i++) begin
            step();
            check($sformatf("bn_q[%0d]", i), 32'(b_q), BN_Q[i]);
            check($sformatf("bn_tc[%0d]", i), 32'(b_tc), BN_TC[i]);
            check($sformatf("bn_dir[%0d]", i), 32'(b_dir), BN_DIR[i]);
        end

        // Out-of-range load clamps to MAX and suppresses the count.
        b_mode = MODE_UP;
        b_load = 1'b1; b_load_val = 3'd7;
        step();
        check("clamp_q", 32'(b_q), 5);
        check("clamp_tc", 32'(b_tc), 0);
        b_load = 1'b0;
        step();
        check("wrap_q", 32'(b_q), 0);
        check("wrap_tc", 32'(b_tc), 1);
        check("wrap_dir", 32'(b_dir), 0);

        // Down wrap sets dir, then bounce continues in the current direction.
        b_mode = MODE_DOWN;
        step();
        check("dwrap_q", 32'(b_q), 5);
        check("dwrap_tc", 32'(b_tc), 1);
        check("dwrap_dir", 32'(b_dir), 1);
        b_mode = MODE_BOUNCE;
        step();
        check("bn_enter_q", 32'(b_q), 4);
        check("bn_enter_tc", 32'(b_tc), 0);
        check("bn_enter_dir", 32'(b_dir), 1);
        b_en = 1'b0;
        step();
        check("b_hold_q", 32'(b_q), 4);

`ifdef COUNTER_GRAY_OUT_EN
        c_prev = c_gray;
        c_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            check($sformatf("gray[%0d]", i), 32'(c_gray), GRAY_SEQ[i]);
            check($sformatf("gray_1bit[%0d]", i), 32'($countones(c_gray ^ c_prev)), 1);
            c_prev = c_gray;
        end
        c_en = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
